// File: rtl/maquina_vendas_param.sv
// Parameterised vending machine: two-digit keypad selection, coin payment,
// single-cycle dispense, unit-by-unit change and full refund on abort/timeout.
module maquina_vendas_param #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int PRICE_W   = 4,
  parameter int CREDIT_W  = 6,
  parameter int COIN_W    = 2,
  parameter int TIMEOUT_T = 15,
  localparam int KEY_MAX  = (ROWS > COLS) ? ROWS : COLS,
  localparam int KEY_W    = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1,
  localparam int N_PROD   = ROWS * COLS,
  localparam int IDX_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick_1hz,
  input  logic                        key_valid,
  input  logic [KEY_W-1:0]            key_code,
  input  logic                        coin_valid,
  input  logic [COIN_W-1:0]           coin_value,
  input  logic                        cancel,
  input  logic [N_PROD*PRICE_W-1:0]   price_table,
  input  logic [N_PROD-1:0]           stock,
  output logic [2:0]                  state,
  output logic [IDX_W-1:0]            prod_idx,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        dispense,
  output logic                        change_pulse,
  output logic                        refund
);

  localparam int TO_W  = $clog2(TIMEOUT_T + 1);
  localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
  localparam logic [KEY_W:0]        ROWS_K     = (KEY_W + 1)'(ROWS);
  localparam logic [KEY_W:0]        COLS_K     = (KEY_W + 1)'(COLS);
  localparam logic [IDX_W-1:0]      COLS_I     = IDX_W'(COLS);
  localparam logic [TO_W-1:0]       TO_LIMIT   = TO_W'(TIMEOUT_T);
  localparam logic [CREDIT_W-1:0]   CREDIT_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_COL  = 3'd1,
    S_PAY      = 3'd2,
    S_DISPENSE = 3'd3,
    S_CHANGE   = 3'd4,
    S_REFUND   = 3'd5
  } state_t;

  state_t               state_q, state_n;
  logic [KEY_W-1:0]     row_q, row_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [PRICE_W-1:0]   price_q, price_n;
  logic [CREDIT_W-1:0]  credit_q, credit_n;
  logic [TO_W-1:0]      tcount_q, tcount_n;

  logic                 coin_ok, key_row_ok, key_col_ok, timeout, in_wait;
  logic [IDX_W-1:0]     idx_calc;
  logic [PRICE_W-1:0]   price_calc;
  logic [CREDIT_W-1:0]  price_ext, credit_sat, credit_pay;
  logic [SUM_W-1:0]     sum;

  // Zero-valued coins are treated as if no coin arrived at all.
  assign coin_ok    = coin_valid && (coin_value != '0);
  assign key_row_ok = key_valid && ({1'b0, key_code} < ROWS_K);
  assign key_col_ok = key_valid && ({1'b0, key_code} < COLS_K);
  assign idx_calc   = IDX_W'(row_q) * COLS_I + IDX_W'(key_code);
  assign price_calc = price_table[int'(idx_calc) * PRICE_W +: PRICE_W];
  assign price_ext  = CREDIT_W'(price_q);
  assign sum        = SUM_W'(credit_q) + SUM_W'(coin_value);
  assign credit_sat = (sum > SUM_W'(CREDIT_SAT)) ? CREDIT_SAT : CREDIT_W'(sum);
  assign credit_pay = coin_ok ? credit_sat : credit_q;
  assign timeout    = (tcount_q == TO_LIMIT);

  always_comb begin
    state_n  = state_q;
    row_n    = row_q;
    idx_n    = idx_q;
    price_n  = price_q;
    credit_n = credit_q;
    case (state_q)
      S_IDLE: begin
        if (key_row_ok) begin
          row_n   = key_code;
          state_n = S_GET_COL;
        end
      end
      S_GET_COL: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (key_col_ok) begin
          idx_n = idx_calc;
          if (stock[idx_calc] && (price_calc != '0)) begin
            price_n = price_calc;
            state_n = S_PAY;
          end else begin
            state_n = S_IDLE;
          end
        end else if (timeout && !key_valid) begin
          state_n = S_IDLE;
        end
      end
      S_PAY: begin
        // A coin arriving with cancel is credited before the refund starts.
        credit_n = credit_pay;
        if (credit_q >= price_ext) begin
          state_n = S_DISPENSE;
        end else if (cancel || (timeout && !coin_ok)) begin
          state_n = (credit_pay != '0) ? S_REFUND : S_IDLE;
        end
      end
      S_DISPENSE: begin
        credit_n = credit_q - price_ext;
        state_n  = (credit_q != price_ext) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE, S_REFUND: begin
        if (credit_q != '0) begin
          credit_n = credit_q - CREDIT_W'(1);
        end
        if (credit_q <= CREDIT_W'(1)) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Inactivity timer only runs while waiting for a key or a coin.
  always_comb begin
    tcount_n = tcount_q;
    in_wait  = ((state_q == S_GET_COL) || (state_q == S_PAY)) && (state_n == state_q);
    if (!in_wait || key_valid || coin_ok) begin
      tcount_n = '0;
    end else if (tick_1hz && !timeout) begin
      tcount_n = tcount_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      idx_q    <= '0;
      price_q  <= '0;
      credit_q <= '0;
      tcount_q <= '0;
    end else begin
      state_q  <= state_n;
      row_q    <= row_n;
      idx_q    <= idx_n;
      price_q  <= price_n;
      credit_q <= credit_n;
      tcount_q <= tcount_n;
    end
  end

  assign state        = state_q;
  assign prod_idx     = idx_q;
  assign credit       = credit_q;
  assign dispense     = (state_q == S_DISPENSE);
  assign change_pulse = (state_q == S_CHANGE) || (state_q == S_REFUND);
  assign refund       = (state_q == S_REFUND);

endmodule

// File: doc/maquina_vendas_param.md
MAQUINA_VENDAS_PARAM -- requirements
Module: maquina_vendas_param

Interface
REQ-001 SHALL provide parameter ROWS, default 4, number of keypad rows (selection first digit).
REQ-002 SHALL provide parameter COLS, default 4, number of keypad columns (selection second digit).
REQ-003 SHALL provide parameter PRICE_W, default 4, width of one price entry.
REQ-004 SHALL provide parameter CREDIT_W, default 6, width of the credit accumulator; CREDIT_W >= PRICE_W+1.
REQ-005 SHALL provide parameter COIN_W, default 2, width of a coin value.
REQ-006 SHALL provide parameter TIMEOUT_T, default 15, inactivity timeout in tick_1hz pulses.
REQ-007 SHALL declare ports, clock and reset first:
 clk  in  1  system clock, rising edge.
 reset  in  1  asynchronous, active-low.
 tick_1hz  in  1  one-cycle timebase strobe.
 key_valid  in  1  one-cycle strobe, key_code valid.
 key_code  in  clog2(max(ROWS,COLS))  digit pressed.
 coin_valid  in  1  one-cycle strobe, coin_value valid.
 coin_value  in  COIN_W  coin value in credit units; 0 ignored.
 cancel  in  1  one-cycle abort request.
 price_table  in  ROWS*COLS*PRICE_W  flat prices, index r*COLS+c at LSBs first.
 stock  in  ROWS*COLS  1 = product present.
 state  out  3  current FSM state.
 prod_idx  out  clog2(ROWS*COLS)  latched selection.
 credit  out  CREDIT_W  current credit.
 dispense  out  1  one-cycle product release pulse.
 change_pulse  out  1  one credit unit returned per asserted cycle.
 refund  out  1  high while returning full credit after abort/timeout.

Function
REQ-008 SHALL implement FSM: IDLE=0, GET_COL=1, PAY=2, DISPENSE=3, CHANGE=4, REFUND=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-009 IDLE: key_valid with key_code < ROWS latches row, -> GET_COL; key_code >= ROWS ignored.
REQ-010 GET_COL: key_valid with key_code < COLS latches col, computes prod_idx = row*COLS+col; if stock[prod_idx]=0 or price=0 -> IDLE, else -> PAY.
REQ-011 GET_COL: key_code >= COLS ignored; cancel or timeout -> IDLE.
REQ-012 PAY: coin_valid adds coin_value to credit, saturating at 2^CREDIT_W-1; excess coin value SHALL be discarded.
REQ-013 PAY: when credit >= price, -> DISPENSE on the next cycle (comparison uses registered credit).
REQ-014 PAY: cancel or timeout with credit > 0 -> REFUND; with credit = 0 -> IDLE.
REQ-015 DISPENSE: dispense SHALL be high exactly one cycle; credit <= credit - price; -> CHANGE if remainder > 0, else IDLE.
REQ-016 CHANGE/REFUND: change_pulse high every cycle, credit decremented by 1 per cycle; when credit reaches 0 -> IDLE in same cycle as final pulse; refund high throughout REFUND only.
REQ-017 Timeout counter SHALL clear on entry to GET_COL/PAY and on any key_valid/coin_valid; incremented on tick_1hz; timeout fires when count = TIMEOUT_T.
REQ-018 Coins in IDLE, GET_COL, DISPENSE, CHANGE, REFUND SHALL be ignored (not credited).
REQ-019 Keys in PAY and later states SHALL be ignored.
REQ-020 Simultaneous coin_valid and cancel in PAY: coin credited first, then whole credit refunded.
REQ-021 Simultaneous coin_valid and timeout in PAY: coin credited and counter cleared; no timeout.
REQ-022 price_table and stock SHALL be sampled only at the GET_COL->PAY transition; price latched for the transaction.

Reset
REQ-023 reset low SHALL asynchronously force state=IDLE, credit=0, prod_idx=0, row=0, timeout count=0, dispense=0, change_pulse=0, refund=0.
REQ-024 Reset mid-transaction SHALL discard credit without any change_pulse.

Verification
REQ-025 Keys 1,2, price[6]=5, coins 2,2,2 -> one dispense pulse, credit 6->1, one change_pulse, IDLE.
REQ-026 Keys 0,3, price exact 3, coins 1,2 -> dispense, no change_pulse, IDLE.
REQ-027 Keys 2,1 with stock[9]=0 -> return to IDLE, no PAY entry.
REQ-028 PAY with credit 4, 15 tick_1hz no activity -> REFUND, 4 change_pulse cycles, refund high, IDLE.
REQ-029 coin_valid and cancel same cycle, credit 2 + coin 1 -> 3 change_pulses.
REQ-030 reset low during CHANGE with credit 3 -> immediate IDLE, credit 0, no further pulses.
